// File: rtl/pads_port_ctrl.sv
// pads_port_ctrl: register-mapped controller for a bank of digital/analog pads.
// It holds per-pad configuration, synchronises and glitch-filters pad inputs,
// and raises sticky edge interrupts. All pad-facing outputs come from flops.
module pads_port_ctrl #(
    parameter int NUMPADS     = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reg_we,
    input  logic               reg_re,
    input  logic [3:0]         reg_addr,
    input  logic [NUMPADS-1:0] reg_wdata,
    output logic [NUMPADS-1:0] reg_rdata,
    input  logic [NUMPADS-1:0] pad_in,
    output logic [NUMPADS-1:0] output_en,
    output logic [NUMPADS-1:0] output_val,
    output logic [NUMPADS-1:0] pullup_en,
    output logic [NUMPADS-1:0] pulldown_en,
    output logic [NUMPADS-1:0] input_en,
    output logic [NUMPADS-1:0] slew_limit_en,
    output logic [NUMPADS-1:0] ana_override,
    output logic               irq
);

    localparam logic [3:0] ADDR_OUT_EN   = 4'd0;
    localparam logic [3:0] ADDR_OUT_VAL  = 4'd1;
    localparam logic [3:0] ADDR_PULL_EN  = 4'd2;
    localparam logic [3:0] ADDR_PULL_DN  = 4'd3;
    localparam logic [3:0] ADDR_SLEW     = 4'd4;
    localparam logic [3:0] ADDR_IN_EN    = 4'd5;
    localparam logic [3:0] ADDR_ANA_OVR  = 4'd6;
    localparam logic [3:0] ADDR_FILT_EN  = 4'd7;
    localparam logic [3:0] ADDR_IRQ_RISE = 4'd8;
    localparam logic [3:0] ADDR_IRQ_FALL = 4'd9;
    localparam logic [3:0] ADDR_IRQ_FLAG = 4'd10;
    localparam logic [3:0] ADDR_IN_VAL   = 4'd11;
    localparam logic [3:0] ADDR_OUT_SET  = 4'd12;
    localparam logic [3:0] ADDR_OUT_CLR  = 4'd13;
    localparam logic [3:0] ADDR_OUT_TGL  = 4'd14;
    localparam logic [3:0] ADDR_FILT_TH  = 4'd15;

    localparam logic [FILT_W-1:0] CNT_ONE = {{(FILT_W-1){1'b0}}, 1'b1};
    localparam logic [FILT_W-1:0] CNT_MAX = {FILT_W{1'b1}};

    // configuration registers
    logic [NUMPADS-1:0] out_en_r,   out_en_s;
    logic [NUMPADS-1:0] out_val_r,  out_val_s;
    logic [NUMPADS-1:0] pull_en_r,  pull_en_s;
    logic [NUMPADS-1:0] pull_dn_r,  pull_dn_s;
    logic [NUMPADS-1:0] slew_r,     slew_s;
    logic [NUMPADS-1:0] in_en_r,    in_en_s;
    logic [NUMPADS-1:0] ana_ovr_r,  ana_ovr_s;
    logic [NUMPADS-1:0] filt_en_r,  filt_en_s;
    logic [NUMPADS-1:0] irq_rise_r, irq_rise_s;
    logic [NUMPADS-1:0] irq_fall_r, irq_fall_s;
    logic [NUMPADS-1:0] irq_flag_r, irq_flag_s;
    logic [FILT_W-1:0]  filt_th_r,  filt_th_s;

    // derived pad-facing flops
    logic [NUMPADS-1:0] output_en_r;
    logic [NUMPADS-1:0] input_en_r;

    // input path
    logic [SYNC_STAGES-1:0][NUMPADS-1:0] sync_r;
    logic [NUMPADS-1:0]                  sync_out_s;
    logic [NUMPADS-1:0]                  filt_r, filt_s;
    logic [NUMPADS-1:0][FILT_W-1:0]      cnt_r, cnt_s;
    logic [NUMPADS-1:0]                  rise_ev_s, fall_ev_s, set_ev_s;

    // bus side
    logic [15:0]        wr_sel_s;
    logic [NUMPADS-1:0] w1c_s;
    logic [NUMPADS-1:0] rdata_s, rdata_r;
    logic               irq_r;

    assign sync_out_s = sync_r[SYNC_STAGES-1];

    // One-hot decode of the write target; all zero when no write is strobed.
    always_comb begin
        wr_sel_s = 16'd0;
        if (reg_we) begin
            wr_sel_s = 16'd1 << reg_addr;
        end else begin
            wr_sel_s = 16'd0;
        end
    end

    // Next-state of the configuration registers, including atomic OUT_VAL ops and W1C flags.
    always_comb begin
        out_en_s   = wr_sel_s[ADDR_OUT_EN]   ? reg_wdata : out_en_r;
        pull_en_s  = wr_sel_s[ADDR_PULL_EN]  ? reg_wdata : pull_en_r;
        pull_dn_s  = wr_sel_s[ADDR_PULL_DN]  ? reg_wdata : pull_dn_r;
        slew_s     = wr_sel_s[ADDR_SLEW]     ? reg_wdata : slew_r;
        in_en_s    = wr_sel_s[ADDR_IN_EN]    ? reg_wdata : in_en_r;
        ana_ovr_s  = wr_sel_s[ADDR_ANA_OVR]  ? reg_wdata : ana_ovr_r;
        filt_en_s  = wr_sel_s[ADDR_FILT_EN]  ? reg_wdata : filt_en_r;
        irq_rise_s = wr_sel_s[ADDR_IRQ_RISE] ? reg_wdata : irq_rise_r;
        irq_fall_s = wr_sel_s[ADDR_IRQ_FALL] ? reg_wdata : irq_fall_r;
        filt_th_s  = wr_sel_s[ADDR_FILT_TH]  ? reg_wdata[FILT_W-1:0] : filt_th_r;
        out_val_s  = wr_sel_s[ADDR_OUT_VAL]  ? reg_wdata :
                     wr_sel_s[ADDR_OUT_SET]  ? (out_val_r | reg_wdata) :
                     wr_sel_s[ADDR_OUT_CLR]  ? (out_val_r & ~reg_wdata) :
                     wr_sel_s[ADDR_OUT_TGL]  ? (out_val_r ^ reg_wdata) :
                                               out_val_r;
        w1c_s      = wr_sel_s[ADDR_IRQ_FLAG] ? reg_wdata : {NUMPADS{1'b0}};
        // a new edge event wins over a simultaneous clear
        irq_flag_s = (irq_flag_r & ~w1c_s) | set_ev_s;
    end

    // Per-pad glitch filter: a disagreeing synchronised value must persist past FILT_TH counts.
    always_comb begin
        filt_s    = filt_r;
        cnt_s     = cnt_r;
        rise_ev_s = {NUMPADS{1'b0}};
        fall_ev_s = {NUMPADS{1'b0}};
        for (int p = 0; p < NUMPADS; p++) begin
            if (!input_en_r[p]) begin
                // disabling the input forces the pad low silently
                filt_s[p] = 1'b0;
                cnt_s[p]  = {FILT_W{1'b0}};
            end else if (!filt_en_r[p] || (sync_out_s[p] == filt_r[p])) begin
                filt_s[p]    = sync_out_s[p];
                cnt_s[p]     = {FILT_W{1'b0}};
                rise_ev_s[p] = sync_out_s[p] & ~filt_r[p];
                fall_ev_s[p] = ~sync_out_s[p] & filt_r[p];
            end else if (cnt_r[p] >= filt_th_r) begin
                filt_s[p]    = sync_out_s[p];
                cnt_s[p]     = {FILT_W{1'b0}};
                rise_ev_s[p] = sync_out_s[p] & ~filt_r[p];
                fall_ev_s[p] = ~sync_out_s[p] & filt_r[p];
            end else if (cnt_r[p] == CNT_MAX) begin
                cnt_s[p] = cnt_r[p];
            end else begin
                cnt_s[p] = cnt_r[p] + CNT_ONE;
            end
        end
        set_ev_s = (rise_ev_s & irq_rise_r) | (fall_ev_s & irq_fall_r);
    end

    // Read mux over the current (pre-write) register state.
    always_comb begin
        rdata_s = {NUMPADS{1'b0}};
        if (reg_re) begin
            case (reg_addr)
                ADDR_OUT_EN:   rdata_s = out_en_r;
                ADDR_OUT_VAL:  rdata_s = out_val_r;
                ADDR_PULL_EN:  rdata_s = pull_en_r;
                ADDR_PULL_DN:  rdata_s = pull_dn_r;
                ADDR_SLEW:     rdata_s = slew_r;
                ADDR_IN_EN:    rdata_s = in_en_r;
                ADDR_ANA_OVR:  rdata_s = ana_ovr_r;
                ADDR_FILT_EN:  rdata_s = filt_en_r;
                ADDR_IRQ_RISE: rdata_s = irq_rise_r;
                ADDR_IRQ_FALL: rdata_s = irq_fall_r;
                ADDR_IRQ_FLAG: rdata_s = irq_flag_r;
                ADDR_IN_VAL:   rdata_s = filt_r;
                ADDR_OUT_SET:  rdata_s = {NUMPADS{1'b0}};
                ADDR_OUT_CLR:  rdata_s = {NUMPADS{1'b0}};
                ADDR_OUT_TGL:  rdata_s = {NUMPADS{1'b0}};
                ADDR_FILT_TH:  rdata_s = {{(NUMPADS-FILT_W){1'b0}}, filt_th_r};
                default:       rdata_s = {NUMPADS{1'b0}};
            endcase
        end else begin
            rdata_s = {NUMPADS{1'b0}};
        end
    end

    // Configuration registers and the derived pad enables, loaded from the same next values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_en_r    <= {NUMPADS{1'b0}};
            out_val_r   <= {NUMPADS{1'b0}};
            pull_en_r   <= {NUMPADS{1'b0}};
            pull_dn_r   <= {NUMPADS{1'b0}};
            slew_r      <= {NUMPADS{1'b0}};
            in_en_r     <= {NUMPADS{1'b0}};
            ana_ovr_r   <= {NUMPADS{1'b0}};
            filt_en_r   <= {NUMPADS{1'b0}};
            irq_rise_r  <= {NUMPADS{1'b0}};
            irq_fall_r  <= {NUMPADS{1'b0}};
            irq_flag_r  <= {NUMPADS{1'b0}};
            filt_th_r   <= {FILT_W{1'b0}};
            output_en_r <= {NUMPADS{1'b0}};
            input_en_r  <= {NUMPADS{1'b0}};
        end else begin
            out_en_r    <= out_en_s;
            out_val_r   <= out_val_s;
            pull_en_r   <= pull_en_s;
            pull_dn_r   <= pull_dn_s;
            slew_r      <= slew_s;
            in_en_r     <= in_en_s;
            ana_ovr_r   <= ana_ovr_s;
            filt_en_r   <= filt_en_s;
            irq_rise_r  <= irq_rise_s;
            irq_fall_r  <= irq_fall_s;
            irq_flag_r  <= irq_flag_s;
            filt_th_r   <= filt_th_s;
            output_en_r <= out_en_s & ~ana_ovr_s;
            input_en_r  <= in_en_s & ~ana_ovr_s;
        end
    end

    // Synchroniser chain fed by the gated pad input, plus the filter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
            filt_r <= {NUMPADS{1'b0}};
            cnt_r  <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pad_in & input_en_r};
            filt_r <= filt_s;
            cnt_r  <= cnt_s;
        end
    end

    // Registered read data and interrupt line.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= {NUMPADS{1'b0}};
            irq_r   <= 1'b0;
        end else begin
            rdata_r <= rdata_s;
            irq_r   <= |irq_flag_r;
        end
    end

    assign reg_rdata     = rdata_r;
    assign output_en     = output_en_r;
    assign output_val    = out_val_r;
    assign pullup_en     = pull_en_r;
    assign pulldown_en   = pull_dn_r;
    assign input_en      = input_en_r;
    assign slew_limit_en = slew_r;
    assign ana_override  = ana_ovr_r;
    assign irq           = irq_r;

endmodule
